// File: rtl/gcn_pkg.sv
// Shared types and default sizes for the GCN aggregation stage.
//   coo_seq_state_t : sequencer FSM states
//   row_t           : one FM x WM product row (WEIGHT_COLS elements)
package gcn_pkg;

  localparam int unsigned FEATURE_ROWS   = 6;
  localparam int unsigned WEIGHT_COLS    = 3;
  localparam int unsigned DOT_PROD_WIDTH = 16;

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_WAIT,
    ST_READ_A,
    ST_ACC_A,
    ST_READ_B,
    ST_ACC_B,
    ST_SELF_RD,
    ST_SELF_ACC,
    ST_DONE
  } coo_seq_state_t;

endpackage

// File: rtl/coo_acc_bank.sv
// Adjacency-result register file: ROWS rows of COLS elements, DW bits each.
//   clk, rst_n       : clock, async active-low reset (clears every row)
//   clear            : zero every row this cycle
//   add_en/addr/row  : acc[add_addr] += add_row element-wise, wrapping mod 2^DW
//   rd_addr/rd_row   : combinational read port
module coo_acc_bank #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 3,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     add_en,
  input  logic [AW-1:0]            add_addr,
  input  logic [COLS-1:0][DW-1:0]  add_row,
  input  logic [AW-1:0]            rd_addr,
  output logic [COLS-1:0][DW-1:0]  rd_row
);

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  logic [COLS-1:0][DW-1:0] acc_q [ROWS];
  logic [COLS-1:0][DW-1:0] acc_d [ROWS];
  logic [COLS-1:0][DW-1:0] sum_c;

  // Element-wise sum of the addressed row and the incoming row.
  always_comb begin
    sum_c = '0;
    if (add_addr <= LAST_ROW) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        sum_c[c] = acc_q[add_addr][c] + add_row[c];
      end
    end
  end

  // Clear has priority over accumulate; out-of-range addresses are dropped.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc_d[r] = '0;
      end
    end else if (add_en && (add_addr <= LAST_ROW)) begin
      acc_d[add_addr] = sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rd_row = (rd_addr <= LAST_ROW) ? acc_q[rd_addr] : '0;

endmodule

// File: rtl/coo_edge_sequencer.sv
// Walks a COO edge list, fetches FM x WM rows per edge endpoint and
// accumulates them into an adjacency-result bank (rows of A*(F*W)).
//   clk, reset               : clock, async active-low reset
//   start, num_edges         : job launch (IDLE only) and edge count
//   undirected, add_self_loops : mode bits latched at start
//   coo_re/coo_addr/coo_data : edge memory port, one-cycle read latency
//   fm_re/fm_addr/fm_data    : FM x WM row memory port, one-cycle read latency
//   out_row/out_data         : combinational result readout
//   busy, done, err_count    : job status
module coo_edge_sequencer #(
  parameter int unsigned FEATURE_ROWS   = gcn_pkg::FEATURE_ROWS,
  parameter int unsigned WEIGHT_COLS    = gcn_pkg::WEIGHT_COLS,
  parameter int unsigned DOT_PROD_WIDTH = gcn_pkg::DOT_PROD_WIDTH,
  parameter int unsigned MAX_EDGES      = 16,
  parameter int unsigned IDX_W          = $clog2(FEATURE_ROWS + 1),
  parameter int unsigned ROW_W          = $clog2(FEATURE_ROWS),
  parameter int unsigned EDGE_W         = $clog2(MAX_EDGES + 1)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [EDGE_W-1:0]                           num_edges,
  input  logic                                        undirected,
  input  logic                                        add_self_loops,
  output logic                                        coo_re,
  output logic [EDGE_W-1:0]                           coo_addr,
  input  logic [1:0][IDX_W-1:0]                       coo_data,
  output logic                                        fm_re,
  output logic [ROW_W-1:0]                            fm_addr,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_data,
  input  logic [ROW_W-1:0]                            out_row,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  out_data,
  output logic                                        busy,
  output logic                                        done,
  output logic [EDGE_W-1:0]                           err_count
);

  import gcn_pkg::*;

  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(MAX_EDGES);
  localparam logic [EDGE_W-1:0] ERR_MAX  = {EDGE_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(FEATURE_ROWS);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FEATURE_ROWS - 1);

  coo_seq_state_t    state_q, state_d;
  logic [EDGE_W-1:0] edge_idx_q, edge_idx_d;
  logic [EDGE_W-1:0] num_edges_q, num_edges_d;
  logic              undirected_q, undirected_d;
  logic              self_loops_q, self_loops_d;
  logic [ROW_W-1:0]  src_q, src_d;
  logic [ROW_W-1:0]  dst_q, dst_d;
  logic [ROW_W-1:0]  node_q, node_d;
  logic [EDGE_W-1:0] err_count_q, err_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              coo_re_q, coo_re_d;
  logic [EDGE_W-1:0] coo_addr_q, coo_addr_d;
  logic              fm_re_q, fm_re_d;
  logic [ROW_W-1:0]  fm_addr_q, fm_addr_d;

  logic [IDX_W-1:0]  src_raw_c, dst_raw_c;
  logic              idx_bad_c;
  logic              last_edge_c;
  coo_seq_state_t    after_edges_c;
  logic              clear_c;
  logic              add_en_c;
  logic [ROW_W-1:0]  add_addr_c;

  // Raw 1-based indices; 0 and anything past the last node are rejected.
  assign src_raw_c     = coo_data[0];
  assign dst_raw_c     = coo_data[1];
  assign idx_bad_c     = (src_raw_c == '0) || (src_raw_c > IDX_MAX) ||
                         (dst_raw_c == '0) || (dst_raw_c > IDX_MAX);
  assign last_edge_c   = (edge_idx_q == (num_edges_q - EDGE_W'(1)));
  assign after_edges_c = self_loops_q ? ST_SELF_RD : ST_DONE;

  // Next-state, datapath control and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    edge_idx_d   = edge_idx_q;
    num_edges_d  = num_edges_q;
    undirected_d = undirected_q;
    self_loops_d = self_loops_q;
    src_d        = src_q;
    dst_d        = dst_q;
    node_d       = node_q;
    err_count_d  = err_count_q;
    clear_c      = 1'b0;
    add_en_c     = 1'b0;
    add_addr_c   = dst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_CLEAR;
          num_edges_d  = (num_edges > EDGE_MAX) ? EDGE_MAX : num_edges;
          undirected_d = undirected;
          self_loops_d = add_self_loops;
          edge_idx_d   = '0;
          err_count_d  = '0;
          node_d       = '0;
        end
      end
      ST_CLEAR: begin
        clear_c = 1'b1;
        state_d = (num_edges_q != '0) ? ST_FETCH : after_edges_c;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (idx_bad_c) begin
          err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + EDGE_W'(1);
          if (last_edge_c) begin
            state_d = after_edges_c;
          end else begin
            edge_idx_d = edge_idx_q + EDGE_W'(1);
            state_d    = ST_FETCH;
          end
        end else begin
          src_d   = ROW_W'(src_raw_c - IDX_W'(1));
          dst_d   = ROW_W'(dst_raw_c - IDX_W'(1));
          state_d = ST_READ_A;
        end
      end
      ST_READ_A: state_d = ST_ACC_A;
      ST_ACC_A: begin
        add_en_c   = 1'b1;
        add_addr_c = dst_q;
        // A self-edge contributes once even in undirected mode.
        if (undirected_q && (src_q != dst_q)) begin
          state_d = ST_READ_B;
        end else if (last_edge_c) begin
          state_d = after_edges_c;
        end else begin
          edge_idx_d = edge_idx_q + EDGE_W'(1);
          state_d    = ST_FETCH;
        end
      end
      ST_READ_B: state_d = ST_ACC_B;
      ST_ACC_B: begin
        add_en_c   = 1'b1;
        add_addr_c = src_q;
        if (last_edge_c) begin
          state_d = after_edges_c;
        end else begin
          edge_idx_d = edge_idx_q + EDGE_W'(1);
          state_d    = ST_FETCH;
        end
      end
      ST_SELF_RD: state_d = ST_SELF_ACC;
      ST_SELF_ACC: begin
        add_en_c   = 1'b1;
        add_addr_c = node_q;
        if (node_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          node_d  = node_q + ROW_W'(1);
          state_d = ST_SELF_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d     = !(state_d inside {ST_IDLE, ST_DONE});
    done_d     = (state_d == ST_DONE);
    coo_re_d   = (state_d == ST_FETCH);
    coo_addr_d = coo_re_d ? edge_idx_d : coo_addr_q;
    fm_re_d    = (state_d inside {ST_READ_A, ST_READ_B, ST_SELF_RD});
    unique case (state_d)
      ST_READ_A:  fm_addr_d = src_d;
      ST_READ_B:  fm_addr_d = dst_q;
      ST_SELF_RD: fm_addr_d = node_d;
      default:    fm_addr_d = fm_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      edge_idx_q   <= '0;
      num_edges_q  <= '0;
      undirected_q <= 1'b0;
      self_loops_q <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      node_q       <= '0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coo_re_q     <= 1'b0;
      coo_addr_q   <= '0;
      fm_re_q      <= 1'b0;
      fm_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      edge_idx_q   <= edge_idx_d;
      num_edges_q  <= num_edges_d;
      undirected_q <= undirected_d;
      self_loops_q <= self_loops_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      node_q       <= node_d;
      err_count_q  <= err_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      coo_re_q     <= coo_re_d;
      coo_addr_q   <= coo_addr_d;
      fm_re_q      <= fm_re_d;
      fm_addr_q    <= fm_addr_d;
    end
  end

  coo_acc_bank #(
    .ROWS (FEATURE_ROWS),
    .COLS (WEIGHT_COLS),
    .DW   (DOT_PROD_WIDTH),
    .AW   (ROW_W)
  ) u_acc_bank (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (clear_c),
    .add_en   (add_en_c),
    .add_addr (add_addr_c),
    .add_row  (fm_data),
    .rd_addr  (out_row),
    .rd_row   (out_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign coo_re    = coo_re_q;
  assign coo_addr  = coo_addr_q;
  assign fm_re     = fm_re_q;
  assign fm_addr   = fm_addr_q;
  assign err_count = err_count_q;

endmodule

// File: doc/coo_edge_sequencer.md
Name: coo_edge_sequencer

Overview:
Sequential successor to the combinational COO row selector in the GCN aggregation stage. It walks a runtime-length COO edge list and fetches the FM×WM product row for each edge endpoint. Each fetched row is accumulated into an on-block adjacency-result bank, giving A·(F·W) rows. It supports directed/undirected edges, optional self-loops, and invalid-index screening; results are read out after done.

Parameters:
FEATURE_ROWS, 6, number of graph nodes / FM_WM rows
WEIGHT_COLS, 3, elements per row
DOT_PROD_WIDTH, 16, element width (accumulation wraps modulo 2^DOT_PROD_WIDTH)
MAX_EDGES, 16, depth of external COO memory
IDX_W, $clog2(FEATURE_ROWS+1), width of a 1-based COO index
ROW_W, $clog2(FEATURE_ROWS), 0-based row address width
EDGE_W, $clog2(MAX_EDGES+1), edge counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
num_edges  in  EDGE_W  edge count, latched at start
undirected  in  1  1: each edge contributes both directions; latched at start
add_self_loops  in  1  1: after edges, acc[r] += FM_WM[r] for all r; latched at start
coo_re  out  1  COO memory read strobe
coo_addr  out  EDGE_W  edge index
coo_data  in  2×IDX_W  [0]=src, [1]=dst, 1-based; valid the cycle after coo_re
fm_re  out  1  FM_WM memory read strobe
fm_addr  out  ROW_W  row index
fm_data  in  WEIGHT_COLS×DOT_PROD_WIDTH  row; valid the cycle after fm_re
out_row  in  ROW_W  result read address
out_data  out  WEIGHT_COLS×DOT_PROD_WIDTH  acc[out_row], combinational
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
err_count  out  EDGE_W  edges skipped for a bad index in the last run

Behaviour:
- Reset (async, reset=0): state IDLE; busy, done, coo_re, fm_re=0; coo_addr, fm_addr, err_count=0; all acc entries=0.
- FSM states: IDLE, CLEAR, FETCH, WAIT, READ_A, ACC_A, READ_B, ACC_B, SELF_RD, SELF_ACC, DONE.
- IDLE: start=1 -> CLEAR; latch the mode inputs and num_edges; edge_idx=0; err_count=0. start is ignored in every other state.
- CLEAR: zero all acc entries in one cycle. Next state: FETCH if num_edges>0; else SELF_RD if add_self_loops; else DONE.
- FETCH: coo_re=1, coo_addr=edge_idx -> WAIT.
- WAIT: convert both indices to 0-based (src=coo_data[0]-1, dst=coo_data[1]-1).
  - If either index is 0 or >FEATURE_ROWS: err_count++ and the edge is skipped (go to the advance step).
  - Otherwise -> READ_A.
- READ_A: fm_re=1, fm_addr=src -> ACC_A.
- ACC_A: acc[dst] += fm_data, element-wise.
  - If undirected and src!=dst -> READ_B; otherwise advance.
  - A self-edge is never double-counted.
- READ_B: fm_addr=dst -> ACC_B.
- ACC_B: acc[src] += fm_data, then advance.
- Advance:
  - If edge_idx==num_edges-1: go to SELF_RD if add_self_loops, else DONE.
  - Otherwise edge_idx++ -> FETCH.
- SELF_RD / SELF_ACC: node counter r = 0..FEATURE_ROWS-1; fm_addr=r, then acc[r] += fm_data; 2 cycles per node -> DONE.
- DONE: done=1 for one cycle; busy drops in the same cycle -> IDLE.
- Latency: 1 (CLEAR) + 4 cycles per directed or self edge + 6 per undirected non-self edge + 2 per skipped edge + 2·FEATURE_ROWS if add_self_loops + 1 (DONE).
- num_edges>MAX_EDGES is clamped to MAX_EDGES.
- err_count saturates at its maximum value.
- out_data is valid only while busy=0; during busy it shows partial sums.
- Reset mid-run aborts immediately: acc cleared, no done pulse.

Decomposition:
- gcn_pkg holds:
  - the state enum (coo_seq_state_t)
  - the row_t typedef (WEIGHT_COLS×DOT_PROD_WIDTH packed array)
  - the default constants FEATURE_ROWS, WEIGHT_COLS, DOT_PROD_WIDTH
- Sub-module coo_acc_bank: FEATURE_ROWS×row_t register file with clear, one add-write port (addr, row, en) and one combinational read port. The sequencer FSM and counters stay in the top module.

Test Plan:
All scenarios use FEATURE_ROWS=6, WEIGHT_COLS=3, memory model fm[r]={r+1, 10(r+1), 100(r+1)}.
1. Directed single edge (1,2), num_edges=1 -> acc[1]={1,10,100}, all other rows 0; done 6 cycles after start; err_count=0.
2. Undirected edge (1,2) -> acc[1]={1,10,100}, acc[0]={2,20,200}; done 8 cycles after start.
3. Undirected self-edge (3,3) plus edge (3,4) -> acc[2]={3,30,300}+{4,40,400}={7,70,700}, acc[3]={3,30,300}.
4. Bad indices: edges (0,2), (7,1), (2,3) directed -> only acc[2]={2,20,200}; err_count=2.
5. add_self_loops=1, num_edges=0 -> acc[r]=fm[r] for every r; done at cycle 2+12. Then reassert reset mid-run of a 16-edge job -> all outputs 0, no done pulse.
6. Wrap case: fm[0]={16'hFFFF,…}, edges (1,2)×2 directed -> acc[1][0]=16'hFFFE. A start pulse asserted during busy is ignored.
